clip_controller: RTL

Control stage directly downstream of the input synchronizer in the clip recorder. Debounces the synchronized `ActionSync` and `resetButtonSync` levels and turns each press into a one-cycle pulse. Runs the record/play state machine for two clips and drives sample-memory address and strobes at a fixed sample rate. Keeps a recorded-length register per clip.

---
 rtl/clip_controller.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/clip_controller.sv
// clip_controller: debounces the action/clear buttons, runs the two-clip record/play FSM and
// issues sample-rate memory strobes. Build macro LOOP_PLAY_EN makes PLAY wrap instead of stopping.
module clip_controller #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int ADDR_WIDTH      = 10,
    parameter int SAMPLE_DIV      = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ActionSync,
    input  logic                resetButtonSync,
    input  logic                ClipNumSync,
    input  logic                PlayOrRecordSync,
    output logic [ADDR_WIDTH:0] mem_addr,
    output logic                mem_we,
    output logic                mem_re,
    output logic                recording,
    output logic                playing,
    output logic                done
);

    localparam int DBW = $clog2(DEBOUNCE_CYCLES);
    localparam int TW  = $clog2(SAMPLE_DIV);

    localparam logic [DBW-1:0]        DB_LAST    = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DBW-1:0]        DB_ONE     = DBW'(1);
    localparam logic [TW-1:0]         TICK_LAST  = TW'(SAMPLE_DIV - 1);
    localparam logic [TW-1:0]         TICK_ONE   = TW'(1);
    localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = '1;
    localparam logic [ADDR_WIDTH-1:0] INDEX_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   LEN_ONE    = (ADDR_WIDTH + 1)'(1);

`ifdef LOOP_PLAY_EN
    localparam bit LOOP_PLAY = 1'b1;
`else
    localparam bit LOOP_PLAY = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECORD = 2'd1,
        PLAY   = 2'd2
    } ctrlStateT;

    // Button conditioning: bit 0 is the action button, bit 1 the clear button.
    logic [1:0]          btnRaw;
    logic [1:0]          btnLevel;
    logic [1:0]          btnLevelD;
    logic [1:0]          btnPulse;
    logic [1:0][DBW-1:0] btnCnt;
    logic                actionPulse;
    logic                clearPulse;

    assign btnRaw      = {resetButtonSync, ActionSync};
    assign actionPulse = btnPulse[0];
    assign clearPulse  = btnPulse[1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            btnLevel  <= '0;
            btnLevelD <= '0;
            btnPulse  <= '0;
            btnCnt    <= '0;
        end else begin
            btnLevelD <= btnLevel;
            btnPulse  <= btnLevel & ~btnLevelD;
            for (int b = 0; b < 2; b++) begin
                if (btnRaw[b] == btnLevel[b]) begin
                    btnCnt[b] <= '0;
                end else if (btnCnt[b] == DB_LAST) begin
                    btnLevel[b] <= btnRaw[b];
                    btnCnt[b]   <= '0;
                end else begin
                    btnCnt[b] <= btnCnt[b] + DB_ONE;
                end
            end
        end
    end

    // Record/play control state.
    ctrlStateT                 state;
    ctrlStateT                 stateNext;
    logic                      clipSel;
    logic                      clipSelNext;
    logic [ADDR_WIDTH-1:0]     index;
    logic [ADDR_WIDTH-1:0]     indexNext;
    logic [1:0][ADDR_WIDTH:0]  clipLen;
    logic [1:0][ADDR_WIDTH:0]  clipLenNext;
    logic [TW-1:0]             tickCnt;
    logic [TW-1:0]             tickCntNext;
    logic                      endPending;
    logic                      endPendingNext;
    logic [ADDR_WIDTH:0]       memAddrNext;
    logic                      weNext;
    logic                      reNext;
    logic                      doneNext;
    logic                      tick;
    logic                      lastPlay;

    assign tick     = (tickCnt == TICK_LAST);
    assign lastPlay = ({1'b0, index} == (clipLen[clipSel] - LEN_ONE));

    always_comb begin
        stateNext      = state;
        clipSelNext    = clipSel;
        indexNext      = index;
        clipLenNext    = clipLen;
        tickCntNext    = tickCnt;
        endPendingNext = 1'b0;
        memAddrNext    = mem_addr;
        weNext         = 1'b0;
        reNext         = 1'b0;
        doneNext       = 1'b0;

        if (clearPulse) begin
            // Clear beats any simultaneous press or tick, and ends silently.
            clipLenNext = '0;
            stateNext   = IDLE;
            tickCntNext = '0;
        end else begin
            case (state)
                IDLE: begin
                    tickCntNext = '0;
                    if (actionPulse) begin
                        if (PlayOrRecordSync) begin
                            stateNext                = RECORD;
                            clipSelNext              = ClipNumSync;
                            indexNext                = '0;
                            clipLenNext[ClipNumSync] = '0;
                        end else if (clipLen[ClipNumSync] != '0) begin
                            stateNext   = PLAY;
                            clipSelNext = ClipNumSync;
                            indexNext   = '0;
                        end
                    end
                end

                RECORD: begin
                    if (actionPulse || endPending) begin
                        stateNext   = IDLE;
                        doneNext    = 1'b1;
                        tickCntNext = '0;
                    end else begin
                        tickCntNext = tick ? '0 : tickCnt + TICK_ONE;
                        if (tick) begin
                            weNext               = 1'b1;
                            memAddrNext          = {clipSel, index};
                            clipLenNext[clipSel] = clipLen[clipSel] + LEN_ONE;
                            // Index stays put on the final slot; the clip is full.
                            if (index == LAST_INDEX) begin
                                endPendingNext = 1'b1;
                            end else begin
                                indexNext = index + INDEX_ONE;
                            end
                        end
                    end
                end

                PLAY: begin
                    if (actionPulse || (endPending && !LOOP_PLAY)) begin
                        stateNext   = IDLE;
                        doneNext    = 1'b1;
                        tickCntNext = '0;
                    end else begin
                        doneNext    = endPending;
                        tickCntNext = tick ? '0 : tickCnt + TICK_ONE;
                        if (tick) begin
                            reNext      = 1'b1;
                            memAddrNext = {clipSel, index};
                            if (lastPlay) begin
                                endPendingNext = 1'b1;
                                indexNext      = LOOP_PLAY ? '0 : index;
                            end else begin
                                indexNext = index + INDEX_ONE;
                            end
                        end
                    end
                end

                default: begin
                    stateNext   = IDLE;
                    tickCntNext = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            clipSel    <= 1'b0;
            index      <= '0;
            clipLen    <= '0;
            tickCnt    <= '0;
            endPending <= 1'b0;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= stateNext;
            clipSel    <= clipSelNext;
            index      <= indexNext;
            clipLen    <= clipLenNext;
            tickCnt    <= tickCntNext;
            endPending <= endPendingNext;
            mem_addr   <= memAddrNext;
            mem_we     <= weNext;
            mem_re     <= reNext;
            done       <= doneNext;
        end
    end

    assign recording = (state == RECORD);
    assign playing   = (state == PLAY);

endmodule
